// File: rtl/rv_pipelined_adder_tree_if.sv
// Beat/result handshake bundle for rv_pipelined_adder_tree.
// The master side drives beats and out_ready. The slave side is the reduction tree.
interface rv_pipelined_adder_tree_if #(
    parameter int N     = 4,
    parameter int DATAW = 8,
    parameter int OUTW  = DATAW + $clog2(N) + 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N*DATAW-1:0]   in_data;
    logic                 in_acc;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUTW-1:0]      out_data;
    logic                 out_ovf;

    modport master (
        output in_valid, in_data, in_acc, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_acc, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/rv_pipelined_adder_tree.sv
// Pipelined N-lane reduction tree with valid/ready flow control.
// Optional multi-beat accumulation uses wrap or saturating adds.
module rv_pipelined_adder_tree #(
    parameter int N      = 4,
    parameter int DATAW  = 8,
    parameter int OUTW   = DATAW + $clog2(N) + 4,
    parameter int SIGNED = 1,
    parameter int SAT    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    rv_pipelined_adder_tree_if.slave bus
);
    localparam int LOGN = $clog2(N);
    localparam int P    = 1 << LOGN;

    logic            stall;
    logic            accept;
    logic [OUTW-1:0] leaf_w [P];

    logic [OUTW-1:0] tail_sum;
    logic            tail_v;
    logic            tail_acc;
    logic            tail_last;

    logic [OUTW-1:0] acc_q, acc_d;
    logic            ovf_acc_q, ovf_acc_d;
    logic [OUTW-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_ovf_q, out_ovf_d;

    logic [OUTW:0]   add_wide;
    logic [OUTW-1:0] add_res;
    logic [OUTW-1:0] add_sat;
    logic            add_ovf;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall;
    assign accept       = bus.in_valid & ~stall;

    // Lanes widened to OUTW; padding leaves up to the next power of two read as zero.
    for (genvar gi = 0; gi < P; gi++) begin : g_leaf
        if (gi < N) begin : g_lane
            logic [DATAW-1:0] lane;
            logic             sx;
            assign lane       = bus.in_data[gi*DATAW +: DATAW];
            assign sx         = (SIGNED != 0) & lane[DATAW-1];
            assign leaf_w[gi] = OUTW'({{OUTW{sx}}, lane});
        end else begin : g_pad
            assign leaf_w[gi] = '0;
        end
    end

    if (LOGN == 0) begin : g_notree
        assign tail_sum  = leaf_w[0];
        assign tail_v    = accept;
        assign tail_acc  = bus.in_acc;
        assign tail_last = bus.in_last;
    end else begin : g_tree
        logic [OUTW-1:0] node_d [LOGN][P/2];
        logic [OUTW-1:0] node_q [LOGN][P/2];
        logic [LOGN-1:0] v_d, v_q, acc_d, acc_q, last_d, last_q;

        always_comb begin
            for (int l = 0; l < LOGN; l++) begin
                for (int j = 0; j < P/2; j++) begin
                    node_d[l][j] = '0;
                end
            end
            for (int j = 0; j < P/2; j++) begin
                node_d[0][j] = leaf_w[2*j] + leaf_w[2*j+1];
            end
            for (int l = 1; l < LOGN; l++) begin
                for (int j = 0; j < (P >> (l+1)); j++) begin
                    node_d[l][j] = node_q[l-1][2*j] + node_q[l-1][2*j+1];
                end
            end
            v_d    = '0;
            acc_d  = '0;
            last_d = '0;
            v_d[0]    = accept;
            acc_d[0]  = bus.in_acc;
            last_d[0] = bus.in_last;
            for (int l = 1; l < LOGN; l++) begin
                v_d[l]    = v_q[l-1];
                acc_d[l]  = acc_q[l-1];
                last_d[l] = last_q[l-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q    <= '0;
                acc_q  <= '0;
                last_q <= '0;
            end else if (!stall) begin
                v_q    <= v_d;
                acc_q  <= acc_d;
                last_q <= last_d;
            end
        end

        always_ff @(posedge clk) begin
            if (!stall) begin
                node_q <= node_d;
            end
        end

        assign tail_sum  = node_q[LOGN-1][0];
        assign tail_v    = v_q[LOGN-1];
        assign tail_acc  = acc_q[LOGN-1];
        assign tail_last = last_q[LOGN-1];
    end

    // Accumulator add; a saturated result feeds later adds in the group.
    always_comb begin
        add_wide = {1'b0, acc_q} + {1'b0, tail_sum};
        add_res  = add_wide[OUTW-1:0];
        if (SIGNED != 0) begin
            add_ovf = (acc_q[OUTW-1] == tail_sum[OUTW-1]) && (add_res[OUTW-1] != acc_q[OUTW-1]);
        end else begin
            add_ovf = add_wide[OUTW];
        end
        add_sat = add_res;
        if ((SAT != 0) && add_ovf) begin
            if (SIGNED != 0) begin
                add_sat = acc_q[OUTW-1] ? {1'b1, {(OUTW-1){1'b0}}} : {1'b0, {(OUTW-1){1'b1}}};
            end else begin
                add_sat = '1;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        if (tail_v) begin
            if (!tail_acc) begin
                out_valid_d = 1'b1;
                out_data_d  = tail_sum;
                out_ovf_d   = 1'b0;
            end else if (!tail_last) begin
                acc_d     = add_sat;
                ovf_acc_d = ovf_acc_q | add_ovf;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = add_sat;
                out_ovf_d   = ovf_acc_q | add_ovf;
                acc_d       = '0;
                ovf_acc_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else if (!stall) begin
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
